key_cmd_ctrl: RTL and testbench

Keypad command conditioner that sits between the keypad driver (`TECLA`/`FLAG`) and the player/bullet movement logic of the VGA game top. It synchronises the raw key-valid flag and debounces press and release. It then turns each accepted press into single-cycle command strobes (`cmd_up`, `cmd_down`, `cmd_fire`, plus a generic `key_pulse`), with timed auto-repeat for held movement keys. The block runs on the main system clock and replaces the ad-hoc slow-clock edge detection in the top.

---
 rtl/key_cmd_ctrl.sv | 176 +++++++++++++++++
 tb/tb_key_cmd_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_ctrl.sv
// Keypad command conditioner: synchronises and debounces the keypad key-valid flag,
// then turns accepted presses into one-cycle command strobes with movement auto-repeat.
module key_cmd_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         REPEAT_DELAY    = 25000000,
    parameter int         REPEAT_RATE     = 5000000,
    parameter logic [3:0] KEY_UP          = 4'd5,
    parameter logic [3:0] KEY_DOWN        = 4'd0,
    parameter logic [3:0] KEY_FIRE        = 4'hA
) (
    input  logic       clk,
    input  logic       nreset_key,
    input  logic [3:0] tecla,
    input  logic       flag,
    output logic       cmd_up,
    output logic       cmd_down,
    output logic       cmd_fire,
    output logic       key_pulse,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int MAX_AB     = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_CYCLES = (MAX_AB > REPEAT_RATE) ? MAX_AB : REPEAT_RATE;
    localparam int CNT_W      = $clog2(MAX_CYCLES);

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_REPEAT,
        S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             held_q, held_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             fire_q, fire_d;
    logic             pulse_q, pulse_d;

    logic             flag_meta_q, flag_s_q;
    logic [3:0]       tecla_meta_q, tecla_s_q;

    logic             strobe;
    logic [3:0]       strobe_code;
    logic             is_move;

    assign is_move = (key_code_q == KEY_UP) || (key_code_q == KEY_DOWN);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        held_d      = held_q;
        strobe      = 1'b0;
        strobe_code = key_code_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (flag_s_q) begin
                    cand_d  = tecla_s_q;
                    state_d = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (!flag_s_q) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (tecla_s_q != cand_q) begin
                    cand_d = tecla_s_q;
                    cnt_d  = '0;
                end else if (cnt_q == DEB_LAST) begin
                    key_code_d  = cand_q;
                    strobe_code = cand_q;
                    strobe      = 1'b1;
                    held_d      = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_PRESSED;
                end
            end
            S_PRESSED: begin
                if (!flag_s_q) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (cnt_q == DELAY_LAST) begin
                    // Non-repeating codes park the counter at its terminal value.
                    cnt_d = cnt_q;
                    if (is_move) begin
                        strobe  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_REPEAT;
                    end
                end
            end
            S_REPEAT: begin
                if (!flag_s_q) begin
                    cnt_d   = '0;
                    state_d = S_RELEASE;
                end else if (cnt_q == RATE_LAST) begin
                    strobe = 1'b1;
                    cnt_d  = '0;
                end
            end
            S_RELEASE: begin
                if (flag_s_q) begin
                    cnt_d   = '0;
                    state_d = S_PRESSED;
                end else if (cnt_q == DEB_LAST) begin
                    held_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        pulse_d = strobe;
        up_d    = strobe && (strobe_code == KEY_UP);
        down_d  = strobe && (strobe_code == KEY_DOWN) && (strobe_code != KEY_UP);
        fire_d  = strobe && (strobe_code == KEY_FIRE) && (strobe_code != KEY_UP)
                         && (strobe_code != KEY_DOWN);
    end

    always_ff @(posedge clk or negedge nreset_key) begin
        if (!nreset_key) begin
            flag_meta_q  <= 1'b0;
            flag_s_q     <= 1'b0;
            tecla_meta_q <= 4'd0;
            tecla_s_q    <= 4'd0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            cand_q       <= 4'd0;
            key_code_q   <= 4'd0;
            held_q       <= 1'b0;
            up_q         <= 1'b0;
            down_q       <= 1'b0;
            fire_q       <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            flag_meta_q  <= flag;
            flag_s_q     <= flag_meta_q;
            tecla_meta_q <= tecla;
            tecla_s_q    <= tecla_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cand_q       <= cand_d;
            key_code_q   <= key_code_d;
            held_q       <= held_d;
            up_q         <= up_d;
            down_q       <= down_d;
            fire_q       <= fire_d;
            pulse_q      <= pulse_d;
        end
    end

    assign cmd_up    = up_q;
    assign cmd_down  = down_q;
    assign cmd_fire  = fire_q;
    assign key_pulse = pulse_q;
    assign key_code  = key_code_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Self-checking bench for key_cmd_ctrl: directed scenarios with literal expectations
// plus randomized key activity checked every cycle against a run-length model.
module tb_key_cmd_ctrl;

    localparam int DEB   = 4;
    localparam int RDEL  = 10;
    localparam int RRATE = 3;

    logic       clk = 1'b0;
    logic       nreset_key = 1'b1;
    logic [3:0] tecla = 4'd0;
    logic       flag = 1'b0;
    logic       cmd_up, cmd_down, cmd_fire, key_pulse, key_held;
    logic [3:0] key_code;

    int tests_run = 0;
    int tests_failed = 0;

    key_cmd_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDEL),
        .REPEAT_RATE    (RRATE),
        .KEY_UP         (4'd5),
        .KEY_DOWN       (4'd0),
        .KEY_FIRE       (4'hA)
    ) dut (
        .clk       (clk),
        .nreset_key(nreset_key),
        .tecla     (tecla),
        .flag      (flag),
        .cmd_up    (cmd_up),
        .cmd_down  (cmd_down),
        .cmd_fire  (cmd_fire),
        .key_pulse (key_pulse),
        .key_code  (key_code),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Reference model: the logic sees inputs two edges late; a press is accepted once
    // the flag has been high with one unchanging code for DEB+1 edges, a release once
    // it has been low for DEB+1 edges, and movement keys repeat at hold ages RDEL+k*RRATE.
    logic       pipe_f0 = 1'b0, pipe_f1 = 1'b0;
    logic [3:0] pipe_t0 = 4'd0, pipe_t1 = 4'd0;
    int         run_len = 0, low_run = 0, age = 0;
    logic [3:0] run_code = 4'd0, m_code = 4'd0;
    logic       m_held = 1'b0, releasing = 1'b0;
    logic       exp_up = 1'b0, exp_down = 1'b0, exp_fire = 1'b0, exp_pulse = 1'b0;
    logic       fs_now, strobe, accepted;
    logic [3:0] ts_now;

    always @(posedge clk or negedge nreset_key) begin
        if (!nreset_key) begin
            pipe_f0 = 1'b0; pipe_f1 = 1'b0; pipe_t0 = 4'd0; pipe_t1 = 4'd0;
            run_len = 0; low_run = 0; age = 0; run_code = 4'd0; m_code = 4'd0;
            m_held = 1'b0; releasing = 1'b0;
            exp_up = 1'b0; exp_down = 1'b0; exp_fire = 1'b0; exp_pulse = 1'b0;
        end else begin
            fs_now  = pipe_f1;
            ts_now  = pipe_t1;
            pipe_f1 = pipe_f0; pipe_t1 = pipe_t0;
            pipe_f0 = flag;    pipe_t0 = tecla;
            strobe   = 1'b0;
            accepted = 1'b0;
            if (fs_now) begin
                if (run_len > 0 && ts_now == run_code) run_len++;
                else begin
                    run_len  = 1;
                    run_code = ts_now;
                end
                low_run = 0;
            end else begin
                run_len = 0;
                low_run++;
            end
            if (!m_held) begin
                if (run_len == DEB + 1) begin
                    m_held = 1'b1; m_code = run_code; age = 0;
                    releasing = 1'b0; strobe = 1'b1; accepted = 1'b1;
                end
            end
            if (m_held && !accepted) begin
                if (fs_now) begin
                    if (releasing) begin
                        releasing = 1'b0;
                        age = 0;
                    end else begin
                        age++;
                        if ((m_code == 4'd5 || m_code == 4'd0) && age >= RDEL && ((age - RDEL) % RRATE) == 0)
                            strobe = 1'b1;
                    end
                end else begin
                    releasing = 1'b1;
                    if (low_run == DEB + 1) begin
                        m_held = 1'b0;
                        releasing = 1'b0;
                    end
                end
            end
            exp_pulse = strobe;
            exp_up    = strobe && m_code == 4'd5;
            exp_down  = strobe && m_code == 4'd0;
            exp_fire  = strobe && m_code == 4'hA;
        end
    end

    // Every-cycle comparison, taken a few time units after the active edge.
    always @(posedge clk) begin
        #3;
        tests_run++;
        if ({cmd_up, cmd_down, cmd_fire, key_pulse, key_code, key_held} !==
            {exp_up, exp_down, exp_fire, exp_pulse, m_code, m_held}) begin
            tests_failed++;
            $display("[TB] FAIL cycle_compare t=%0t: got up=%b down=%b fire=%b pulse=%b code=%h held=%b, expected up=%b down=%b fire=%b pulse=%b code=%h held=%b",
                     $time, cmd_up, cmd_down, cmd_fire, key_pulse, key_code, key_held,
                     exp_up, exp_down, exp_fire, exp_pulse, m_code, m_held);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive inputs at a falling edge, then let n falling edges pass.
    task automatic applyStimulus(input logic f, input logic [3:0] t, input int n);
        flag  = f;
        tecla = t;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] all_outputs();
        return 32'({cmd_up, cmd_down, cmd_fire, key_pulse, key_code, key_held});
    endfunction

    logic [3:0] code_pool [5];
    logic [3:0] cur_code;

    initial begin
        #2 nreset_key = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", all_outputs(), 32'd0);
        nreset_key = 1'b1;
        applyStimulus(1'b0, 4'd0, 3);
        checkOutput("idle_after_reset", all_outputs(), 32'd0);

        // Scenario 1: clean press and release of code 5.
        applyStimulus(1'b1, 4'd5, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("s1_cmd_up", 32'(cmd_up), 32'(i == 6));
            checkOutput("s1_model_pulse", 32'(exp_pulse), 32'(i == 6));
            checkOutput("s1_no_down_fire", 32'({cmd_down, cmd_fire}), 32'd0);
            if (i == 6) checkOutput("s1_key_code", 32'(key_code), 32'd5);
            checkOutput("s1_key_held", 32'(key_held), 32'(i >= 6));
        end
        applyStimulus(1'b0, 4'd5, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("s1_release_held", 32'(key_held), 32'(i < 6));
            checkOutput("s1_release_no_pulse", 32'(key_pulse), 32'd0);
        end

        // Scenario 2: bouncy press, then steady.
        applyStimulus(1'b1, 4'd5, 2);
        applyStimulus(1'b0, 4'd5, 2);
        applyStimulus(1'b1, 4'd5, 2);
        applyStimulus(1'b0, 4'd5, 2);
        applyStimulus(1'b1, 4'd5, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("s2_cmd_up", 32'(cmd_up), 32'(i == 6));
        end
        applyStimulus(1'b0, 4'd5, 10);

        // Scenario 3: hold the down key, auto-repeat.
        applyStimulus(1'b1, 4'd0, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkOutput("s3_cmd_down", 32'(cmd_down),
                        32'((i == 6) || (i >= 16 && ((i - 16) % 3) == 0)));
            checkOutput("s3_no_up", 32'(cmd_up), 32'd0);
        end
        applyStimulus(1'b0, 4'd0, 10);

        // Scenario 4: hold fire, no repeat.
        applyStimulus(1'b1, 4'hA, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checkOutput("s4_cmd_fire", 32'(cmd_fire), 32'(i == 6));
            checkOutput("s4_key_pulse", 32'(key_pulse), 32'(i == 6));
            checkOutput("s4_key_held", 32'(key_held), 32'(i >= 6));
        end
        applyStimulus(1'b0, 4'hA, 10);

        // Scenario 5: code change mid-hold is ignored; unmapped code gives only key_pulse.
        applyStimulus(1'b1, 4'd5, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("s5_cmd_up", 32'(cmd_up), 32'(i == 6));
        end
        applyStimulus(1'b1, 4'd0, 0);
        for (int i = 8; i < 15; i++) begin
            @(negedge clk);
            checkOutput("s5_change_no_pulse", 32'(key_pulse), 32'd0);
            checkOutput("s5_change_code", 32'(key_code), 32'd5);
        end
        applyStimulus(1'b0, 4'd0, 10);
        applyStimulus(1'b1, 4'd7, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("s5_code7_pulse", 32'(key_pulse), 32'(i == 6));
            checkOutput("s5_code7_no_cmd", 32'({cmd_up, cmd_down, cmd_fire}), 32'd0);
            if (i == 6) checkOutput("s5_code7_key_code", 32'(key_code), 32'd7);
        end
        applyStimulus(1'b0, 4'd7, 10);

        // Scenario 6: reset during a repeat strobe, then a fresh press with flag held.
        applyStimulus(1'b1, 4'd0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("s6_cmd_down", 32'(cmd_down),
                        32'((i == 6) || (i >= 16 && ((i - 16) % 3) == 0)));
        end
        nreset_key = 1'b0;
        #1;
        checkOutput("s6_reset_kills_strobe", all_outputs(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("s6_reset_held", all_outputs(), 32'd0);
        nreset_key = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("s6_fresh_down", 32'(cmd_down), 32'(i == 6));
            checkOutput("s6_fresh_held", 32'(key_held), 32'(i >= 6));
        end
        applyStimulus(1'b0, 4'd0, 10);

        // Randomized key activity, including short glitches and occasional resets.
        code_pool[0] = 4'd5; code_pool[1] = 4'd0; code_pool[2] = 4'hA; code_pool[3] = 4'd7;
        code_pool[4] = 4'd0;
        cur_code = 4'd5;
        for (int s = 0; s < 90; s++) begin
            if ($urandom_range(0, 29) == 0) begin
                nreset_key = 1'b0;
                repeat (2) @(negedge clk);
                nreset_key = 1'b1;
            end else begin
                if ($urandom_range(0, 2) == 0) begin
                    code_pool[4] = 4'($urandom_range(0, 15));
                    cur_code = code_pool[$urandom_range(0, 4)];
                end
                applyStimulus(1'($urandom_range(0, 2) != 0), cur_code, $urandom_range(1, 14));
            end
        end
        applyStimulus(1'b0, 4'd0, 12);
        checkOutput("final_idle_held", 32'(key_held), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
